// File: rtl/byte_serializer.sv
// Byte-wide valid/ready input, one-deep holding register, and a bit-serial
// output stage with a programmable bit period and selectable bit order.
module byte_serializer #(
    parameter int BIT_DIV   = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic       SOUT,
    output logic       SOUT_VALID,
    output logic       FRAME_START,
    output logic       BUSY
);
    localparam int             CW       = $clog2(BIT_DIV + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BIT_DIV - 1);
    localparam logic [0:0]     IDLE     = 1'b0;
    localparam logic [0:0]     SHIFT    = 1'b1;

    logic [0:0]    state, state_n;
    logic          hold_full, hold_full_n;
    logic [7:0]    hold_data;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic          accept, bit_end, frame_end, load, sout_n;

    always_comb begin
        accept    = DIN_VALID & DIN_READY;
        bit_end   = (state == SHIFT) && (cnt == CNT_LAST);
        frame_end = bit_end && (bit_idx == 3'd7);
        // A queued byte loads either from IDLE or at the edge closing bit 7,
        // which is what makes back-to-back frames gapless.
        load      = hold_full && ((state == IDLE) || frame_end);

        state_n = state;
        if (load)
            state_n = SHIFT;
        else if (frame_end)
            state_n = IDLE;

        hold_full_n = (hold_full & ~load) | accept;

        if (load)
            shreg_n = hold_data;
        else if (LSB_FIRST)
            shreg_n = {1'b0, shreg[7:1]};
        else
            shreg_n = {shreg[6:0], 1'b0};

        sout_n = LSB_FIRST ? shreg_n[0] : shreg_n[7];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            hold_full   <= 1'b0;
            hold_data   <= 8'd0;
            shreg       <= 8'd0;
            bit_idx     <= 3'd0;
            cnt         <= '0;
            DIN_READY   <= 1'b0;
            SOUT        <= 1'b0;
            SOUT_VALID  <= 1'b0;
            FRAME_START <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            state       <= state_n;
            hold_full   <= hold_full_n;
            DIN_READY   <= ~hold_full_n;
            BUSY        <= hold_full_n | (state_n == SHIFT);
            FRAME_START <= load;
            if (accept)
                hold_data <= DIN;

            if (load) begin
                shreg      <= shreg_n;
                bit_idx    <= 3'd0;
                cnt        <= '0;
                SOUT       <= sout_n;
                SOUT_VALID <= 1'b1;
            end else if (state == SHIFT) begin
                if (bit_end) begin
                    cnt <= '0;
                    if (frame_end) begin
                        SOUT       <= 1'b0;
                        SOUT_VALID <= 1'b0;
                    end else begin
                        shreg   <= shreg_n;
                        bit_idx <= bit_idx + 3'd1;
                        SOUT    <= sout_n;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
- Parallel-to-serial read-out end for byte data captured in the byte register file.
- Accepts one byte at a time over a valid/ready handshake.
- Holds each accepted byte in a one-deep holding register, then shifts it out one bit at a time on a single line, with a programmable bit period.
- Drives LED/GPIO pins or a downstream serial link directly.

Parameters:
- BIT_DIV, 4: clock cycles each bit is held on SOUT. Legal range is 1..65535.
- LSB_FIRST, 1: 1 = bit 0 is sent first; 0 = bit 7 is sent first.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- DIN  input  8  byte to serialize; sampled on an accept edge.
- DIN_VALID  input  1  DIN holds a byte to transfer.
- DIN_READY  output  1  holding register can accept a byte.
- SOUT  output  1  serial data bit.
- SOUT_VALID  output  1  SOUT carries a data bit.
- FRAME_START  output  1  one-cycle pulse on the first cycle of bit 0 of each byte.
- BUSY  output  1  holding register full or shifter active.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is asynchronous and active-low.
  - While RST_N is 0: SOUT=0, SOUT_VALID=0, FRAME_START=0, BUSY=0, DIN_READY=0, holding register empty, state IDLE.
  - All outputs are registered.
- DIN_READY:
  - Registered. It equals "holding register empty after this edge".
  - After reset deassert it rises at the first CLK edge.
- Accept:
  - A byte is accepted at a rising edge where DIN_VALID=1 and DIN_READY=1. DIN is copied into the holding register, which becomes full.
  - DIN_VALID while DIN_READY=0 has no effect. DIN may change freely while it is not being accepted.
- States and transitions:
  - IDLE: SOUT_VALID=0 and SOUT=0.
    - If the holding register is full at an edge, the byte moves to the shifter, the holding register empties, and the state goes to SHIFT.
  - SHIFT: an 8-bit shift register, a 3-bit bit index and a BIT_DIV cycle counter are active.
    - Each bit is presented for exactly BIT_DIV cycles, and SOUT_VALID=1 throughout.
    - At the edge ending bit index 7:
      - Holding register full: load it into the shifter at that same edge and stay in SHIFT. Streaming is gapless.
      - Holding register empty: go to IDLE.
- Latency:
  - Byte accepted at edge k from IDLE with an empty holding register: shifter loads at edge k+1.
  - SOUT_VALID=1, FRAME_START=1 and SOUT=first bit in the cycle after edge k+1.
  - The last bit ends at edge k+1+8*BIT_DIV.
- Throughput:
  - The holding register empties at the load edge, so DIN_READY is 1 after that edge. The next byte can be queued during the current frame.
  - With continuous input, sustained rate is one byte per 8*BIT_DIV cycles.
- Bit order:
  - LSB_FIRST=1 sends DIN[0] to DIN[7].
  - LSB_FIRST=0 sends DIN[7] to DIN[0].
- Counters:
  - The cycle counter is ceil(log2(BIT_DIV+1)) bits wide and runs 0..BIT_DIV-1, then wraps.
  - The bit index wraps 7 to 0 only on a load.
  - BIT_DIV=1 gives one bit per cycle.
- BUSY = holding register full OR state is SHIFT. Registered.
- Simultaneous events:
  - An accept edge and the shifter's load edge never coincide for the same register, because DIN_READY=0 while it is full.
  - An accept in the cycle right after a load is legal.
- Reset mid-frame: the frame is aborted immediately, outputs go to their reset values, and the queued byte is discarded. There is no partial-frame resume.

Test Plan:
- Reset/idle (BIT_DIV=2, LSB_FIRST=1): hold RST_N=0 for 5 cycles, then release → during reset all outputs 0; DIN_READY=1 one edge after release; SOUT_VALID stays 0 with no input.
- Single byte: accept 0xA5 at edge k (BIT_DIV=2, LSB_FIRST=1) → FRAME_START pulse after edge k+1; SOUT sequence 1,0,1,0,0,1,0,1, each bit for 2 cycles; SOUT_VALID=1 for exactly 16 cycles; BUSY drops to 0 after the last bit.
- Back-to-back: offer 0x3C then 0xFF with DIN_VALID held high (BIT_DIV=1) → second byte accepted while the first is shifting; no idle gap between frames; FRAME_START pulses exactly 8 cycles apart; 16 contiguous SOUT_VALID cycles.
- Backpressure: holding register full and shifter busy → DIN_READY=0; a changing DIN with DIN_VALID=1 is ignored; the accepted value is the one present at the edge where DIN_READY=1.
- MSB-first (LSB_FIRST=0, BIT_DIV=3): send 0x81 → SOUT 1,0,0,0,0,0,0,1, each bit for 3 cycles.
- Reset mid-frame: assert RST_N=0 asynchronously during bit 4 of 0x5A with a second byte queued → outputs clear without waiting for a clock edge; after release there is no output until a new byte is accepted.
